ifetch_decd: RTL
================

Name: ifetch_decd

Overview:
- Instruction-fetch and decode stage of the multicycle MIPS32 core; sits directly upstream of the main controller.
- Owns the PC register and performs the instruction-memory read handshake into an instruction register (IR).
- Decodes the IR into the 7-bit decoded-op code consumed by the controller.
- Consumes the controller's PC-write, next-PC-select and ALU zero flag to compute and commit the next PC.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset; must be word aligned.

Ports:
- clk  in  1  system clock, rising edge.
- clr_n  in  1  asynchronous active-low reset.
- fetch_en  in  1  one-cycle strobe from controller Fetch state; starts a fetch at current PC.
- pc_upd  in  1  next-PC commit strobe (end of instruction).
- pc_wr  in  1  controller PC-write enable; qualifies pc_upd.
- npc_op  in  2  00 sequential, 01 beq, 10 j, 11 treated as 00.
- zero  in  1  ALU zero flag for beq.
- im_req  out  1  instruction-memory read request.
- im_addr  out  32  byte address = PC, bits[1:0] always 00.
- im_rdata  in  32  instruction word, valid when im_ready.
- im_ready  in  1  memory data-valid/accept.
- instr  out  32  instruction register.
- decd_op  out  7  decoded op (codes below), registered with instr.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4, combinational from pc.
- ir_valid  out  1  IR holds a fetched, undiscarded instruction.
- busy  out  1  fetch in progress.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (clr_n low, async): pc=RESET_PC, instr=0, decd_op=0000000, im_req=0, ir_valid=0, busy=0, err=0, state=IDLE. Reset mid-fetch abandons the request immediately; a late im_ready is ignored.
- FSM states: IDLE, REQ, HOLD.
- IDLE: fetch_en -> REQ next cycle with im_req=1, busy=1.
- REQ:
  - im_req and im_addr held stable until im_ready.
  - On the cycle im_ready=1: instr<=im_rdata, decd_op<=decode(im_rdata), ir_valid<=1, im_req<=0, -> HOLD. Fetch latency is 1 + memory wait cycles; zero-wait memory gives IR valid 2 cycles after fetch_en.
  - fetch_en in REQ: ignored.
  - pc_upd in REQ: ignored; err<=1.
- HOLD:
  - IR stable. fetch_en -> REQ for a refetch at the current PC.
  - pc_upd -> IDLE, ir_valid<=0.
- PC commit: when pc_upd && pc_wr in IDLE or HOLD, pc <= npc on the next edge. pc_upd with pc_wr=0 leaves pc unchanged but still clears ir_valid.
- npc computation, all arithmetic mod 2^32 (wrap FFFF_FFFC+4 = 0):
  - 00: pc+4.
  - 01: zero ? pc+4+(sext(instr[15:0])<<2) : pc+4.
  - 10: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - npc bits[1:0] forced 00.
- Simultaneous fetch_en and pc_upd in HOLD: the commit applies first and the fetch uses the new PC; state -> REQ.
- Decode (opcode=instr[31:26], funct=instr[5:0]):
  - addu: op 000000, funct 100001 -> 1000011.
  - subu: op 000000, funct 100011 -> 1000111.
  - ori: op 001101 -> 0011010.
  - lw: op 100011 -> 1000110.
  - sw: op 101011 -> 1010110.
  - beq: op 000100 -> 0001000.
  - j: op 000010 -> 0000100.
  - Anything else -> 0000000 (nop).
- err clears only on reset.

Decomposition:
- Shared package mips_defs holds:
  - the decd_op code constants;
  - npc_op encodings (nml/beq/j);
  - MIPS opcode and funct constants;
  - FSM state encoding.
- The controller includes the same package.
- One natural sub-module is instr_decode: the combinational IR-to-decd_op mapping, reused by the verification scoreboard.

Test Plan:
- Reset release, fetch_en pulse, zero-wait memory returning 32'h0043_2021 (addu) -> im_addr=0x3000, ir_valid=1 two cycles after the strobe, decd_op=1000011.
- im_ready delayed 3 cycles, im_rdata=32'h3421_00FF (ori) -> im_req held high 4 cycles with address stable, decd_op=0011010.
- IR=32'h1022_FFFE (beq, imm=-2) at pc 0x3008, zero=1, pc_upd+pc_wr, npc_op=01 -> pc=0x3004. Same with zero=0 -> pc=0x300C.
- IR=32'h0800_0C10 (j) at pc 0x3010, npc_op=10, commit -> pc=0x0000_3040.
- pc=0xFFFF_FFFC, npc_op=00, commit -> pc=0x0000_0000. Then IR=32'hFC00_0000 -> decd_op=0000000.
- pc_upd during REQ -> pc unchanged, err=1. clr_n low mid-REQ -> im_req=0, pc=0x3000 immediately.

Source files
------------

// File: rtl/ifetch_decd_pkg.sv
// Shared MIPS32 definitions for the fetch/decode stage and the main controller:
// decoded-op codes, next-PC selects, opcode/funct values and fetch FSM encoding.
package ifetch_decd_pkg;

    localparam logic [6:0] DOP_NOP  = 7'b0000000;
    localparam logic [6:0] DOP_ADDU = 7'b1000011;
    localparam logic [6:0] DOP_SUBU = 7'b1000111;
    localparam logic [6:0] DOP_ORI  = 7'b0011010;
    localparam logic [6:0] DOP_LW   = 7'b1000110;
    localparam logic [6:0] DOP_SW   = 7'b1010110;
    localparam logic [6:0] DOP_BEQ  = 7'b0001000;
    localparam logic [6:0] DOP_J    = 7'b0000100;

    localparam logic [1:0] NPC_NML = 2'b00;
    localparam logic [1:0] NPC_BEQ = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_HOLD = 2'b10
    } fetch_state_e;

    // Branch displacement: sign-extended 16-bit word offset scaled to bytes.
    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_decd_if.sv
// Instruction-memory read port: request/address out, data/ready back.
interface ifetch_decd_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic        im_ready;

    modport master (output im_req, im_addr, input im_rdata, im_ready);
    modport slave  (input im_req, im_addr, output im_rdata, im_ready);
endinterface

// File: rtl/ifetch_decd_instr_decode.sv
// Combinational instruction-word to decoded-op mapping; unknown encodings decode as nop.
module ifetch_decd_instr_decode
    import ifetch_decd_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [6:0]  o_decd_op
);
    logic [5:0] w_opcode;
    logic [5:0] w_funct;

    assign w_opcode = i_instr[31:26];
    assign w_funct  = i_instr[5:0];

    always_comb begin
        o_decd_op = DOP_NOP;
        case (w_opcode)
            OP_RTYPE: begin
                if (w_funct == FUNCT_ADDU)      o_decd_op = DOP_ADDU;
                else if (w_funct == FUNCT_SUBU) o_decd_op = DOP_SUBU;
            end
            OP_ORI:  o_decd_op = DOP_ORI;
            OP_LW:   o_decd_op = DOP_LW;
            OP_SW:   o_decd_op = DOP_SW;
            OP_BEQ:  o_decd_op = DOP_BEQ;
            OP_J:    o_decd_op = DOP_J;
            default: o_decd_op = DOP_NOP;
        endcase
    end
endmodule

// File: rtl/ifetch_decd.sv
// Fetch/decode stage of the multicycle MIPS32 core: owns the PC, fetches into the IR,
// decodes it, and commits the next PC when the controller ends an instruction.
module ifetch_decd
    import ifetch_decd_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              fetch_en,
    input  logic              pc_upd,
    input  logic              pc_wr,
    input  logic [1:0]        npc_op,
    input  logic              zero,
    ifetch_decd_if.master     im,
    output logic [31:0]       instr,
    output logic [6:0]        decd_op,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4,
    output logic              ir_valid,
    output logic              busy,
    output logic              err
);
    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic [6:0]   r_decd_op;
    logic         r_ir_valid;
    logic         r_err;
    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_npc;
    logic [6:0]   w_decd_op;
    logic         w_load;
    logic         w_upd;
    logic         w_err_set;
    logic         w_commit;

    ifetch_decd_instr_decode u_decode (
        .i_instr   (im.im_rdata),
        .o_decd_op (w_decd_op)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_upd       = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_upd = pc_upd;
                if (fetch_en) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                // A commit while the bus is busy is a controller bug: drop it and flag it.
                w_err_set = pc_upd;
                if (im.im_ready) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_upd = pc_upd;
                if (fetch_en)    w_state_nxt = ST_REQ;
                else if (pc_upd) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_commit   = w_upd & pc_wr;
    assign w_pc_plus4 = r_pc + 32'd4;

    always_comb begin
        case (npc_op)
            NPC_BEQ: w_npc = zero ? (w_pc_plus4 + br_offset(r_instr[15:0])) : w_pc_plus4;
            NPC_J:   w_npc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
            default: w_npc = w_pc_plus4;
        endcase
        w_npc[1:0] = 2'b00;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_decd_op  <= DOP_NOP;
            r_ir_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_commit) r_pc <= w_npc;
            if (w_load) begin
                r_instr   <= im.im_rdata;
                r_decd_op <= w_decd_op;
            end
            if (w_load)     r_ir_valid <= 1'b1;
            else if (w_upd) r_ir_valid <= 1'b0;
            if (w_err_set) r_err <= 1'b1;
        end
    end

    assign im.im_req  = (r_state == ST_REQ);
    assign im.im_addr = r_pc;
    assign busy       = (r_state == ST_REQ);
    assign instr      = r_instr;
    assign decd_op    = r_decd_op;
    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;
    assign ir_valid   = r_ir_valid;
    assign err        = r_err;
endmodule
